// File: rtl/memory_access_unit.sv
// Load/store unit: turns byte/half/word core requests into word-addressed memory
// accesses with lane enables, splitting boundary-crossing accesses in two.
module memory_access_unit #(
   parameter int DATA_WIDTH       = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic                  reqStore,
   input  logic [1:0]            reqSize,
   input  logic                  reqUnsigned,
   input  logic [DATA_WIDTH-1:0] reqAddress,
   input  logic [DATA_WIDTH-1:0] reqWriteData,
   output logic                  respValid,
   input  logic                  respReady,
   output logic [DATA_WIDTH-1:0] respData,
   output logic                  respFault,
   output logic [DATA_WIDTH-1:0] memAddress,
   output logic [DATA_WIDTH-1:0] memDataWrite,
   output logic [3:0]            memByteSelect,
   output logic                  memStore,
   output logic                  memLoad,
   input  logic [DATA_WIDTH-1:0] memDataRead
);

   typedef enum logic [2:0] {IDLE, ACC1, ACC2, LDCAP, RESP} stateType;

   stateType                  state;
   logic                      regStore;
   logic [2:0]                regBytes;
   logic                      regUnsigned;
   logic [DATA_WIDTH-1:0]     regAddress;
   logic [DATA_WIDTH-1:0]     regWriteData;
   logic                      regCross;
   logic [DATA_WIDTH-1:0]     loWord;

   logic [2:0]                reqBytes;
   logic [3:0]                reqEnd;
   logic                      reqCross;
   logic                      reqAligned;
   logic [1:0]                offset;
   logic [DATA_WIDTH-1:0]     baseAddress;
   logic [3:0]                byteMask;
   logic [7:0]                laneMask;
   logic [2*DATA_WIDTH-1:0]   storeWide;
   logic [2*DATA_WIDTH-1:0]   loadPair;

   // Shift the two-word window down to the addressed byte, then sign/zero extend.
   function automatic logic [DATA_WIDTH-1:0] extendLoad(
      input logic [2*DATA_WIDTH-1:0] pair,
      input logic [1:0]              off,
      input logic [2:0]              nBytes,
      input logic                    isUnsigned
   );
      logic [2*DATA_WIDTH-1:0] shifted;
      shifted = pair >> {off, 3'b000};
      case (nBytes)
         3'd1:    extendLoad = isUnsigned ? DATA_WIDTH'(shifted[7:0])
                                          : DATA_WIDTH'($signed(shifted[7:0]));
         3'd2:    extendLoad = isUnsigned ? DATA_WIDTH'(shifted[15:0])
                                          : DATA_WIDTH'($signed(shifted[15:0]));
         default: extendLoad = shifted[DATA_WIDTH-1:0];
      endcase
   endfunction

   always_comb begin
      reqBytes   = 3'd4;
      reqAligned = (reqAddress[1:0] == 2'b00);
      case (reqSize)
         2'd0: begin
            reqBytes   = 3'd1;
            reqAligned = 1'b1;
         end
         2'd1: begin
            reqBytes   = 3'd2;
            reqAligned = !reqAddress[0];
         end
         default: ;
      endcase
   end

   assign reqEnd   = {2'b00, reqAddress[1:0]} + {1'b0, reqBytes};
   assign reqCross = (reqEnd > 4'd4);
   assign reqReady = (state == IDLE);

   assign offset      = regAddress[1:0];
   assign baseAddress = {regAddress[DATA_WIDTH-1:2], 2'b00};
   assign byteMask    = (regBytes == 3'd1) ? 4'b0001 :
                        (regBytes == 3'd2) ? 4'b0011 : 4'b1111;
   assign laneMask    = {4'b0000, byteMask} << offset;
   assign storeWide   = {{DATA_WIDTH{1'b0}}, regWriteData} << {offset, 3'b000};
   assign loadPair    = regCross ? {memDataRead, loWord}
                                 : {{DATA_WIDTH{1'b0}}, memDataRead};

   // Control and response registers: the only state that reset touches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         respValid <= 1'b0;
         respFault <= 1'b0;
         respData  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (reqValid) begin
                  if (ALLOW_MISALIGNED == 0 && !reqAligned) begin
                     state     <= RESP;
                     respValid <= 1'b1;
                     respFault <= 1'b1;
                  end else begin
                     state <= ACC1;
                  end
               end
            end
            ACC1: begin
               if (regCross) begin
                  state <= ACC2;
               end else if (regStore) begin
                  state     <= RESP;
                  respValid <= 1'b1;
               end else begin
                  state <= LDCAP;
               end
            end
            ACC2: begin
               if (regStore) begin
                  state     <= RESP;
                  respValid <= 1'b1;
               end else begin
                  state <= LDCAP;
               end
            end
            LDCAP: begin
               respData  <= extendLoad(loadPair, offset, regBytes, regUnsigned);
               respValid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (respReady) begin
                  respValid <= 1'b0;
                  respFault <= 1'b0;
                  respData  <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request and low-word capture carry no reset; they are only read after being loaded.
   always_ff @(posedge clk) begin
      if (state == IDLE && reqValid) begin
         regStore     <= reqStore;
         regBytes     <= reqBytes;
         regUnsigned  <= reqUnsigned;
         regAddress   <= reqAddress;
         regWriteData <= reqWriteData;
         regCross     <= reqCross;
      end
      if (state == ACC2) begin
         loWord <= memDataRead;
      end
   end

   always_comb begin
      memAddress    = '0;
      memDataWrite  = '0;
      memByteSelect = 4'b0000;
      memStore      = 1'b0;
      memLoad       = 1'b0;
      case (state)
         ACC1: begin
            memAddress = baseAddress;
            memStore   = regStore;
            memLoad    = !regStore;
            if (regStore) begin
               memByteSelect = laneMask[3:0];
               memDataWrite  = storeWide[DATA_WIDTH-1:0];
            end
         end
         ACC2: begin
            memAddress = baseAddress + DATA_WIDTH'(4);
            memStore   = regStore;
            memLoad    = !regStore;
            if (regStore) begin
               memByteSelect = laneMask[7:4];
               memDataWrite  = storeWide[2*DATA_WIDTH-1:DATA_WIDTH];
            end
         end
         default: ;
      endcase
   end

endmodule
